// File: rtl/dds_ctrl_pkg.sv
// Shared types and constants for the DDS tuning-word controller.
package dds_ctrl_pkg;

    localparam int NUM_REQ = 8;

    // Default step sizes and limits (32-bit DDS accumulator)
    localparam logic [31:0] DEF_STEP_COARSE  = 32'd429497;
    localparam logic [31:0] DEF_STEP_MICRO   = 32'd4295;
    localparam logic [31:0] DEF_STEP_NANO    = 32'd43;
    localparam logic [31:0] DEF_PHASE_STEP   = 32'd1073741824;
    localparam logic [31:0] DEF_FREQ_DEFAULT = 32'd4294967;
    localparam logic [31:0] DEF_FREQ_MAX     = 32'h7FFF_FFFF;
    localparam logic [23:0] DEF_HOLD_CYCLES  = 24'd5_000_000;
    localparam logic [23:0] DEF_REPEAT_CYCLES = 24'd1_000_000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    // Request index follows the port order; bit 0 set means "subtract"
    typedef enum logic [2:0] {
        REQ_ADD       = 3'd0,
        REQ_SUB       = 3'd1,
        REQ_MICRO_ADD = 3'd2,
        REQ_MICRO_SUB = 3'd3,
        REQ_NANO_ADD  = 3'd4,
        REQ_NANO_SUB  = 3'd5,
        REQ_PHASE_ADD = 3'd6,
        REQ_PHASE_SUB = 3'd7
    } req_idx_t;

    function automatic logic req_is_sub(input req_idx_t idx);
        return idx[0];
    endfunction

    function automatic logic req_is_phase(input req_idx_t idx);
        return (idx[2:1] == 2'b11);
    endfunction

endpackage

// File: rtl/tuning_word_ctrl_btn_sync.sv
// One-bit two-flop synchronizer for an active-low button; resets to released.
module btn_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of the asynchronous level, idle-high on reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/tuning_word_ctrl.sv
// DDS frequency/phase tuning-word controller: debounced-by-FSM button
// stepping with press-and-hold auto-repeat and frequency saturation.
module tuning_word_ctrl
    import dds_ctrl_pkg::*;
#(
    parameter logic [31:0] STEP_COARSE   = DEF_STEP_COARSE,
    parameter logic [31:0] STEP_MICRO    = DEF_STEP_MICRO,
    parameter logic [31:0] STEP_NANO     = DEF_STEP_NANO,
    parameter logic [31:0] PHASE_STEP    = DEF_PHASE_STEP,
    parameter logic [31:0] FREQ_DEFAULT  = DEF_FREQ_DEFAULT,
    parameter logic [31:0] FREQ_MAX      = DEF_FREQ_MAX,
    parameter logic [23:0] HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter logic [23:0] REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sw_add_n,
    input  logic        sw_sub_n,
    input  logic        sw_micro_add_n,
    input  logic        sw_micro_sub_n,
    input  logic        sw_nano_add_n,
    input  logic        sw_nano_sub_n,
    input  logic        phase_add_n,
    input  logic        phase_sub_n,
    output logic [31:0] freq_word,
    output logic [31:0] phase_word,
    output logic        update,
    output logic        sat
);

    logic [NUM_REQ-1:0] req_n;
    logic [NUM_REQ-1:0] sync_n;
    logic [NUM_REQ-1:0] low;

    logic     dec_vld;
    req_idx_t dec_idx;
    logic     req_vld;
    req_idx_t req_idx;

    logic [1:0] prime;
    logic       armed;

    state_t     state, state_nx;
    logic [23:0] cnt, cnt_nx;
    req_idx_t   lat_idx, lat_nx;
    logic       do_step;
    logic       match;

    logic [31:0] step_amt;
    logic [32:0] sum33;
    logic [31:0] freq_calc;
    logic        sat_calc;
    logic [31:0] phase_calc;

    assign req_n = {phase_sub_n, phase_add_n, sw_nano_sub_n, sw_nano_add_n,
                    sw_micro_sub_n, sw_micro_add_n, sw_sub_n, sw_add_n};

    btn_sync u_sync [NUM_REQ-1:0] (
        .clk   (clk),
        .reset (reset),
        .d     (req_n),
        .q     (sync_n)
    );

    assign low = ~sync_n;

    // Decode: a request counts only when exactly one button is down
    always_comb begin
        dec_vld = $onehot(low);
        dec_idx = REQ_ADD;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (low[i]) dec_idx = req_idx_t'(3'(i));
        end
    end

    // Register the decoded request; this stage sets the press-to-output latency
    always_ff @(posedge clk) begin
        if (!reset) begin
            req_vld <= 1'b0;
            req_idx <= REQ_ADD;
        end else begin
            req_vld <= dec_vld;
            req_idx <= dec_idx;
        end
    end

    // Arm once every button reads released. The synchronizer reset value
    // looks "released", so wait until real samples have flushed through it;
    // otherwise a button held across reset would arm immediately.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prime <= 2'b00;
            armed <= 1'b0;
        end else begin
            prime <= {prime[0], 1'b1};
            if (prime[1] && (&sync_n)) armed <= 1'b1;
        end
    end

    assign match = req_vld && (req_idx == lat_idx);

    // FSM state, hold/repeat counter and latched request
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            lat_idx <= REQ_ADD;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            lat_idx <= lat_nx;
        end
    end

    // Next-state: step on press, after the hold delay, then every repeat period
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        lat_nx   = lat_idx;
        do_step  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (armed && req_vld) begin
                    do_step  = 1'b1;
                    lat_nx   = req_idx;
                    cnt_nx   = '0;
                    state_nx = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!match) begin
                    cnt_nx   = '0;
                    state_nx = ST_IDLE;
                end else if (cnt == HOLD_CYCLES - 24'd1) begin
                    do_step  = 1'b1;
                    cnt_nx   = '0;
                    state_nx = ST_REPEAT;
                end else begin
                    cnt_nx = cnt + 24'd1;
                end
            end
            ST_REPEAT: begin
                if (!match) begin
                    cnt_nx   = '0;
                    state_nx = ST_IDLE;
                end else if (cnt == REPEAT_CYCLES - 24'd1) begin
                    do_step = 1'b1;
                    cnt_nx  = '0;
                end else begin
                    cnt_nx = cnt + 24'd1;
                end
            end
            default: begin
                cnt_nx   = '0;
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Step datapath: clamped frequency add/sub, wrapping phase add/sub
    always_comb begin
        case (req_idx)
            REQ_ADD, REQ_SUB:             step_amt = STEP_COARSE;
            REQ_MICRO_ADD, REQ_MICRO_SUB: step_amt = STEP_MICRO;
            REQ_NANO_ADD, REQ_NANO_SUB:   step_amt = STEP_NANO;
            default:                      step_amt = PHASE_STEP;
        endcase
        sum33     = {1'b0, freq_word} + {1'b0, step_amt};
        freq_calc = freq_word;
        sat_calc  = 1'b0;
        if (req_is_sub(req_idx)) begin
            if (step_amt > freq_word) begin
                freq_calc = '0;
                sat_calc  = 1'b1;
            end else begin
                freq_calc = freq_word - step_amt;
            end
        end else begin
            if (sum33 > {1'b0, FREQ_MAX}) begin
                freq_calc = FREQ_MAX;
                sat_calc  = 1'b1;
            end else begin
                freq_calc = sum33[31:0];
            end
        end
        phase_calc = req_is_sub(req_idx) ? (phase_word - step_amt)
                                         : (phase_word + step_amt);
    end

    // Output words and one-cycle update/sat pulses; one word per step
    always_ff @(posedge clk) begin
        if (!reset) begin
            freq_word  <= FREQ_DEFAULT;
            phase_word <= '0;
            update     <= 1'b0;
            sat        <= 1'b0;
        end else begin
            update <= do_step;
            sat    <= 1'b0;
            if (do_step) begin
                if (req_is_phase(req_idx)) begin
                    phase_word <= phase_calc;
                end else begin
                    freq_word <= freq_calc;
                    sat       <= sat_calc;
                end
            end
        end
    end

endmodule

// File: tb/tb_tuning_word_ctrl.sv
// Directed self-checking bench for tuning_word_ctrl with short hold/repeat.
module tb_tuning_word_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  btn_n = 8'hFF;
    logic [31:0] freq_word;
    logic [31:0] phase_word;
    logic        update;
    logic        sat;

    int n_pass = 0;
    int n_total = 0;
    int upd_cnt = 0;
    int sat_cnt = 0;
    int upd_snap;
    int sat_snap;

    always #5 clk = ~clk;

    tuning_word_ctrl #(
        .STEP_COARSE   (32'd1000),
        .STEP_MICRO    (32'd500),
        .FREQ_DEFAULT  (32'd5000),
        .FREQ_MAX      (32'd10000),
        .HOLD_CYCLES   (24'd8),
        .REPEAT_CYCLES (24'd4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .sw_add_n       (btn_n[0]),
        .sw_sub_n       (btn_n[1]),
        .sw_micro_add_n (btn_n[2]),
        .sw_micro_sub_n (btn_n[3]),
        .sw_nano_add_n  (btn_n[4]),
        .sw_nano_sub_n  (btn_n[5]),
        .phase_add_n    (btn_n[6]),
        .phase_sub_n    (btn_n[7]),
        .freq_word      (freq_word),
        .phase_word     (phase_word),
        .update         (update),
        .sat            (sat)
    );

    // Pulse counters sampled shortly after each rising edge
    always @(posedge clk) begin
        #1;
        if (update === 1'b1) upd_cnt <= upd_cnt + 1;
        if (sat === 1'b1)    sat_cnt <= sat_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d (0x%08h) expected %0d (0x%08h)", tag, obs, obs, exp, exp);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(6);
    endtask

    task automatic press(input int idx, input int cycles);
        btn_n[idx] = 1'b0;
        tick(cycles);
        btn_n[idx] = 1'b1;
        tick(10);
    endtask

    initial begin
        // Reset state
        tick(3);
        check("rst_freq", freq_word, 32'd5000);
        check("rst_phase", phase_word, 32'd0);
        check("rst_update", {31'd0, update}, 32'd0);
        check("rst_sat", {31'd0, sat}, 32'd0);
        reset = 1'b1;
        tick(6);

        // Single coarse add: result lands exactly three edges after first sample
        upd_snap = upd_cnt;
        btn_n[0] = 1'b0;
        tick(2);
        btn_n[0] = 1'b1;
        tick(1);
        check("lat_n2_freq", freq_word, 32'd5000);
        check("lat_n2_upd", {31'd0, update}, 32'd0);
        tick(1);
        check("lat_n3_freq", freq_word, 32'd6000);
        check("lat_n3_upd", {31'd0, update}, 32'd1);
        tick(1);
        check("lat_n4_upd", {31'd0, update}, 32'd0);
        tick(15);
        check("single_freq", freq_word, 32'd6000);
        check("single_upd_cnt", 32'(upd_cnt - upd_snap), 32'd1);

        // Nano add held 30 cycles: +0, +8, then every 4
        do_reset();
        upd_snap = upd_cnt;
        btn_n[4] = 1'b0;
        tick(4);
        check("rep_press", freq_word, 32'd5043);
        tick(7);
        check("rep_before_hold", freq_word, 32'd5043);
        tick(1);
        check("rep_hold", freq_word, 32'd5086);
        tick(4);
        check("rep_first_repeat", freq_word, 32'd5129);
        tick(14);
        btn_n[4] = 1'b1;
        tick(10);
        check("rep_final", freq_word, 32'd5301);
        check("rep_upd_cnt", 32'(upd_cnt - upd_snap), 32'd7);

        // Upper saturation
        do_reset();
        for (int i = 0; i < 4; i++) press(0, 2);
        press(2, 2);
        check("sat_setup", freq_word, 32'd9500);
        sat_snap = sat_cnt;
        press(0, 2);
        check("sat_clamp", freq_word, 32'd10000);
        check("sat_pulse", 32'(sat_cnt - sat_snap), 32'd1);
        upd_snap = upd_cnt;
        sat_snap = sat_cnt;
        press(0, 2);
        check("sat_again_freq", freq_word, 32'd10000);
        check("sat_again_upd", 32'(upd_cnt - upd_snap), 32'd1);
        check("sat_again_sat", 32'(sat_cnt - sat_snap), 32'd1);

        // Lower saturation: 5000 - 6*1000 clamps at zero
        do_reset();
        for (int i = 0; i < 5; i++) press(1, 2);
        check("low_setup", freq_word, 32'd0);
        sat_snap = sat_cnt;
        press(1, 2);
        check("low_clamp", freq_word, 32'd0);
        check("low_sat", 32'(sat_cnt - sat_snap), 32'd1);

        // Two buttons together: no request until one is released
        do_reset();
        upd_snap = upd_cnt;
        btn_n[0] = 1'b0;
        btn_n[1] = 1'b0;
        tick(6);
        check("multi_none", 32'(upd_cnt - upd_snap), 32'd0);
        btn_n[1] = 1'b1;
        tick(3);
        btn_n[0] = 1'b1;
        tick(10);
        check("multi_freq", freq_word, 32'd6000);
        check("multi_upd_cnt", 32'(upd_cnt - upd_snap), 32'd1);

        // Phase wraps, never saturates
        do_reset();
        for (int i = 0; i < 3; i++) press(6, 2);
        check("ph_setup", phase_word, 32'hC000_0000);
        sat_snap = sat_cnt;
        press(6, 2);
        check("ph_wrap", phase_word, 32'h0000_0000);
        check("ph_no_sat", 32'(sat_cnt - sat_snap), 32'd0);
        check("ph_freq_kept", freq_word, 32'd5000);
        press(7, 2);
        check("ph_sub_wrap", phase_word, 32'hC000_0000);

        // Button held through reset must be released before it acts
        btn_n[1] = 1'b0;
        reset = 1'b0;
        tick(3);
        upd_snap = upd_cnt;
        reset = 1'b1;
        tick(20);
        check("held_freq", freq_word, 32'd5000);
        check("held_upd_cnt", 32'(upd_cnt - upd_snap), 32'd0);
        btn_n[1] = 1'b1;
        tick(6);
        press(1, 2);
        check("held_repress", freq_word, 32'd4000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tuning_word_ctrl.md
TUNING_WORD_CTRL -- requirements
Module: tuning_word_ctrl

Interface
REQ-001 Parameter STEP_COARSE, default 32'd429497, is the frequency word step for coarse add/sub.
REQ-002 Parameter STEP_MICRO, default 32'd4295, is the frequency word step for micro add/sub.
REQ-003 Parameter STEP_NANO, default 32'd43, is the frequency word step for nano add/sub.
REQ-004 Parameter PHASE_STEP, default 32'd1073741824, is the phase word step (90 degrees).
REQ-005 Parameter FREQ_DEFAULT, default 32'd4294967, is the frequency word after reset.
REQ-006 Parameter FREQ_MAX, default 32'h7FFF_FFFF, is the upper saturation limit; the lower limit is 0.
REQ-007 Parameter HOLD_CYCLES, default 24'd5_000_000, is the press-and-hold delay before auto-repeat starts.
REQ-008 Parameter REPEAT_CYCLES, default 24'd1_000_000, is the auto-repeat period.
REQ-009 Port clk, input, 1, is the system clock.
REQ-010 Port reset, input, 1, is the reset: synchronous, active-low.
REQ-011 Ports sw_add_n, sw_sub_n, sw_micro_add_n, sw_micro_sub_n, sw_nano_add_n, sw_nano_sub_n, input, 1 each, are the active-low frequency step requests (level, asynchronous).
REQ-012 Ports phase_add_n, phase_sub_n, input, 1 each, are the active-low phase step requests (level, asynchronous).
REQ-013 Port freq_word, output, 32, is the registered DDS frequency tuning word.
REQ-014 Port phase_word, output, 32, is the registered DDS phase offset word.
REQ-015 Port update, output, 1, pulses high for one cycle in every cycle where freq_word or phase_word is written.
REQ-016 Port sat, output, 1, pulses high for one cycle when a frequency step is clamped.

Function
- REQ-017 Each of the 8 request inputs SHALL pass through a 2-flop synchronizer before use.
- REQ-018 A request is "valid" when exactly one synchronized input is low; zero or multiple lows SHALL count as no request.
- REQ-019 The FSM SHALL have the states IDLE, HOLD and REPEAT, plus a 1-bit `armed` flag.
- REQ-020 In IDLE with armed=1 and a valid request: apply one step, latch the request index, clear the counter, and go to HOLD.
- REQ-021 In HOLD: if the latched request is not the current valid request (released, changed, or multiple), go to IDLE with no step; otherwise, when the counter reaches HOLD_CYCLES-1, apply one step, clear the counter, and go to REPEAT.
- REQ-022 In REPEAT: if the request is released, changed, or multiple, go to IDLE; otherwise apply one step each time the counter reaches REPEAT_CYCLES-1, then clear the counter.
- REQ-023 The latency from an input sampled low at edge N (IDLE, armed) SHALL be: freq_word/phase_word and update change at edge N+3.
- REQ-024 Frequency add SHALL be computed in 33 bits; a result > FREQ_MAX SHALL load FREQ_MAX and pulse sat.
- REQ-025 Frequency sub SHALL also be clamped: a step > freq_word SHALL load 0 and pulse sat.
- REQ-026 A step at a limit when already at that limit SHALL pulse both update and sat, leaving the word unchanged.
- REQ-027 Phase add/sub SHALL wrap modulo 2^32, with no saturation and no sat pulse.
- REQ-028 At most one step SHALL be applied per cycle.
- REQ-029 Frequency and phase SHALL never both change in the same cycle.
- REQ-030 `armed` SHALL clear on reset and set in the first cycle in which all synchronized inputs are high.
- REQ-031 No step SHALL occur while armed=0, so a button held through reset requires release before it acts.

Reset
- REQ-032 While reset=0 at a rising clk edge, the block SHALL load:
  - freq_word=FREQ_DEFAULT, phase_word=0, update=0, sat=0
  - FSM=IDLE, counter=0, armed=0
  - all synchronizer flops =1
- REQ-033 Reset asserted mid-HOLD or mid-REPEAT SHALL abort without applying any pending step.

Structure
- REQ-034 Package dds_ctrl_pkg SHALL hold the FSM state enum, the 3-bit request index encoding (0..7 in port order above), and the default step constants.
- REQ-035 Sub-module btn_sync (one-bit 2-flop synchronizer, reset value 1) SHALL be instantiated once per request input.
- REQ-036 The step/clamp datapath and the FSM SHALL live in tuning_word_ctrl.

Verification
Bench parameters: HOLD_CYCLES=8, REPEAT_CYCLES=4, STEP_COARSE=1000, FREQ_DEFAULT=5000, FREQ_MAX=10000.
- REQ-037 Reset, then sw_add_n low for 2 cycles: freq_word=6000 with one update pulse at edge N+3; no further change.
- REQ-038 Hold sw_nano_add_n low for 30 cycles: exactly one step at press, one at +8 cycles, then one every 4 cycles until release.
- REQ-039 freq_word=9500, then sw_add_n pressed: freq_word=10000 with sat pulse; pressing again gives update+sat with freq_word unchanged.
- REQ-040 sw_add_n and sw_sub_n low together: no update; releasing sw_sub_n alone then applies a single +1000 step.
- REQ-041 phase_word=32'hC000_0000, then phase_add_n pressed: phase_word=0, no sat pulse.
- REQ-042 Hold sw_sub_n low across reset: freq_word stays 5000 until release and re-press, then becomes 4000.
